ex_cc_stage: RTL and testbench

Execute-stage back end of the pipelined CPU: consumes the ALU's result (valE) and flag vector (CC), keeps the architectural condition-code register, evaluates jump/conditional-move conditions, and forms the E→M pipeline register with stall/bubble control. It sits directly downstream of the ALU and upstream of the memory stage.

---
 rtl/ex_cc_stage_pkg.sv | 42 ++++
 rtl/ex_cc_stage_cond_eval.sv | 41 ++++
 rtl/ex_cc_stage.sv | 112 +++++++++++
 tb/tb_ex_cc_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_cc_stage_pkg.sv
// ex_cc_stage_pkg: shared constants for the execute-stage back end.
//   - DATA_WID default datapath width
//   - instruction codes, status codes, RNONE register id
//   - condition-code bit positions and jXX/cmovXX condition selectors
package ex_cc_stage_pkg;

    localparam int DATA_WID = 32;

    typedef enum logic [3:0] {
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IOPQ    = 4'h6,
        IJXX    = 4'h7
    } icode_e;

    typedef enum logic [2:0] {
        SAOK = 3'h1,
        SADR = 3'h2,
        SINS = 3'h3,
        SHLT = 3'h4
    } stat_e;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6,
        C_B   = 4'h7,
        C_AE  = 4'h8
    } cond_e;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int unsigned CC_ZF = 0;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 2;
    localparam int unsigned CC_CF = 3;

endpackage

// File: rtl/ex_cc_stage_cond_eval.sv
// cond_eval: combinational condition evaluation for jXX / cmovXX.
// Ports:
//   i_cc   [3:0] condition codes {CF,OF,SF,ZF}
//   i_ifun [3:0] condition selector
//   o_cnd        condition result
// Config macro: CC_CARRY_EN enables the carry-based conditions (b / ae);
// without it those selectors evaluate to 0.
module cond_eval
    import ex_cc_stage_pkg::*;
(
    input  logic [3:0] i_cc,
    input  logic [3:0] i_ifun,
    output logic       o_cnd
);

    logic w_zf, w_sf, w_of, w_lt;

    assign w_zf = i_cc[CC_ZF];
    assign w_sf = i_cc[CC_SF];
    assign w_of = i_cc[CC_OF];
    assign w_lt = w_sf ^ w_of;

    always_comb begin
        o_cnd = 1'b0;
        case (i_ifun)
            C_YES:   o_cnd = 1'b1;
            C_LE:    o_cnd = w_lt | w_zf;
            C_L:     o_cnd = w_lt;
            C_E:     o_cnd = w_zf;
            C_NE:    o_cnd = ~w_zf;
            C_GE:    o_cnd = ~w_lt;
            C_G:     o_cnd = ~w_lt & ~w_zf;
`ifdef CC_CARRY_EN
            C_B:     o_cnd = i_cc[CC_CF];
            C_AE:    o_cnd = ~i_cc[CC_CF];
`endif
            default: o_cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_cc_stage.sv
// ex_cc_stage: execute-stage back end. Holds the architectural condition-code
// register, evaluates e_cnd from it, and forms the E->M pipeline register
// with stall (hold) / bubble (NOP) control.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   E_icode/ifun/stat/valA/dstE/dstM  execute-stage instruction fields
//   alu_valE, alu_cc               ALU result and flags {CF,OF,SF,ZF}
//   mw_exc                         exception in M/W, blocks CC update
//   m_stall, m_bubble              E->M register control (stall wins)
//   e_cnd                          combinational condition result
//   cc_q                           architectural CC register
//   M_*                            E->M register contents
// Config macro: CC_CARRY_EN stores CF; otherwise cc_q[3] is held at 0.
module ex_cc_stage
    import ex_cc_stage_pkg::*;
#(
    parameter int DATA_WID = ex_cc_stage_pkg::DATA_WID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          E_icode,
    input  logic [3:0]          E_ifun,
    input  logic [2:0]          E_stat,
    input  logic [DATA_WID-1:0] E_valA,
    input  logic [3:0]          E_dstE,
    input  logic [3:0]          E_dstM,
    input  logic [DATA_WID-1:0] alu_valE,
    input  logic [3:0]          alu_cc,
    input  logic                mw_exc,
    input  logic                m_stall,
    input  logic                m_bubble,
    output logic                e_cnd,
    output logic [3:0]          cc_q,
    output logic [3:0]          M_icode,
    output logic [2:0]          M_stat,
    output logic                M_cnd,
    output logic [DATA_WID-1:0] M_valE,
    output logic [DATA_WID-1:0] M_valA,
    output logic [3:0]          M_dstE,
    output logic [3:0]          M_dstM
);

    logic [3:0]          r_cc;
    logic [3:0]          r_icode;
    logic [2:0]          r_stat;
    logic                r_cnd;
    logic [DATA_WID-1:0] r_valE;
    logic [DATA_WID-1:0] r_valA;
    logic [3:0]          r_dstE;
    logic [3:0]          r_dstM;

    logic       w_cnd;
    logic       w_cc_we;
    logic [3:0] w_cc_next;
    logic [3:0] w_dstE;

    cond_eval u_cond_eval (
        .i_cc   (r_cc),
        .i_ifun (E_ifun),
        .o_cnd  (w_cnd)
    );

    assign w_cc_we = (E_icode == IOPQ) && !mw_exc && (E_stat == SAOK);

`ifdef CC_CARRY_EN
    assign w_cc_next = alu_cc;
`else
    assign w_cc_next = {1'b0, alu_cc[2:0]};
`endif

    // A cmov whose condition fails must not write its destination.
    assign w_dstE = ((E_icode == IRRMOVQ) && !w_cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= 4'b0001;
        end else if (w_cc_we) begin
            r_cc <= w_cc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (!m_stall && m_bubble)) begin
            r_icode <= INOP;
            r_stat  <= SAOK;
            r_cnd   <= 1'b0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
        end else if (!m_stall) begin
            r_icode <= E_icode;
            r_stat  <= E_stat;
            r_cnd   <= w_cnd;
            r_valE  <= alu_valE;
            r_valA  <= E_valA;
            r_dstE  <= w_dstE;
            r_dstM  <= E_dstM;
        end
    end

    assign e_cnd   = w_cnd;
    assign cc_q    = r_cc;
    assign M_icode = r_icode;
    assign M_stat  = r_stat;
    assign M_cnd   = r_cnd;
    assign M_valE  = r_valE;
    assign M_valA  = r_valA;
    assign M_dstE  = r_dstE;
    assign M_dstM  = r_dstM;

endmodule

// File: tb/tb_ex_cc_stage.sv
module tb_ex_cc_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    E_icode, E_ifun, E_dstE, E_dstM;
    logic [2:0]    E_stat;
    logic [W-1:0]  E_valA, alu_valE;
    logic [3:0]    alu_cc;
    logic          mw_exc, m_stall, m_bubble;
    logic          e_cnd;
    logic [3:0]    cc_q;
    logic [3:0]    M_icode, M_dstE, M_dstM;
    logic [2:0]    M_stat;
    logic          M_cnd;
    logic [W-1:0]  M_valE, M_valA;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit           m_init = 0;
    logic [3:0]   m_cc;
    logic [3:0]   m_icode, m_dstE, m_dstM;
    logic [2:0]   m_stat;
    logic         m_cnd;
    logic [W-1:0] m_valE, m_valA;

    ex_cc_stage #(.DATA_WID(W)) dut (
        .clk(clk), .rst(rst),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
        .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .alu_valE(alu_valE), .alu_cc(alu_cc),
        .mw_exc(mw_exc), .m_stall(m_stall), .m_bubble(m_bubble),
        .e_cnd(e_cnd), .cc_q(cc_q),
        .M_icode(M_icode), .M_stat(M_stat), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Conditions phrased as comparisons of the last ALU result:
    // "signed less" is SF!=OF, "equal" is ZF, "unsigned below" is CF.
    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] ifun);
        bit eq, less, below, carry_ok;
        eq    = cc[0];
        less  = (cc[1] != cc[2]);
        below = cc[3];
`ifdef CC_CARRY_EN
        carry_ok = 1;
`else
        carry_ok = 0;
`endif
        if (ifun == 0) return 1;
        if (ifun == 1) return less || eq;
        if (ifun == 2) return less;
        if (ifun == 3) return eq;
        if (ifun == 4) return !eq;
        if (ifun == 5) return !less;
        if (ifun == 6) return !less && !eq;
        if (ifun == 7) return carry_ok && below;
        if (ifun == 8) return carry_ok && !below;
        return 0;
    endfunction

    task automatic set_idle();
        rst = 0; E_icode = 4'h1; E_ifun = 0; E_stat = 3'h1;
        E_valA = '0; E_dstE = 4'hF; E_dstM = 4'hF;
        alu_valE = '0; alu_cc = 0; mw_exc = 0; m_stall = 0; m_bubble = 0;
    endtask

    // One clock: check e_cnd before the edge, advance the model, check state after.
    task automatic cycle();
        bit c;
        #1;
        c = m_init ? ref_cond(m_cc, E_ifun) : 1'b0;
        if (m_init) chk("e_cnd", {31'b0, e_cnd}, {31'b0, c});
        if (rst) begin
            m_cc = 4'b0001;
            m_icode = 4'h1; m_stat = 3'h1; m_cnd = 0; m_valE = '0; m_valA = '0;
            m_dstE = 4'hF; m_dstM = 4'hF;
            m_init = 1;
        end else begin
            if (m_stall) begin
                // hold
            end else if (m_bubble) begin
                m_icode = 4'h1; m_stat = 3'h1; m_cnd = 0; m_valE = '0; m_valA = '0;
                m_dstE = 4'hF; m_dstM = 4'hF;
            end else begin
                m_icode = E_icode; m_stat = E_stat; m_cnd = c;
                m_valE = alu_valE; m_valA = E_valA; m_dstM = E_dstM;
                m_dstE = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
            end
            if (E_icode == 4'h6 && !mw_exc && E_stat == 3'h1) begin
`ifdef CC_CARRY_EN
                m_cc = alu_cc;
`else
                m_cc = {1'b0, alu_cc[2:0]};
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("cc_q",    {28'b0, cc_q},    {28'b0, m_cc});
        chk("M_icode", {28'b0, M_icode}, {28'b0, m_icode});
        chk("M_stat",  {29'b0, M_stat},  {29'b0, m_stat});
        chk("M_cnd",   {31'b0, M_cnd},   {31'b0, m_cnd});
        chk("M_valE",  M_valE, m_valE);
        chk("M_valA",  M_valA, m_valA);
        chk("M_dstE",  {28'b0, M_dstE},  {28'b0, m_dstE});
        chk("M_dstM",  {28'b0, M_dstM},  {28'b0, m_dstM});
    endtask

    task automatic opq(input logic [3:0] flags, input logic exc);
        set_idle(); E_icode = 4'h6; E_ifun = 4'h1; alu_cc = flags; mw_exc = exc;
        alu_valE = $urandom; E_valA = $urandom; E_dstE = 4'h2; E_dstM = 4'hF;
        cycle();
    endtask

    task automatic jxx(input logic [3:0] fn);
        set_idle(); E_icode = 4'h7; E_ifun = fn; E_valA = $urandom; alu_valE = $urandom;
        cycle();
    endtask

    initial begin
        // reset
        set_idle(); rst = 1; cycle();
        chk("rst_cc_const", {28'b0, cc_q}, 32'h1);
        chk("rst_dstE_const", {28'b0, M_dstE}, 32'hF);

        // sub 5-5 -> ZF; je taken, jne not
        opq(4'b0001, 0);
        jxx(4'h3);
        jxx(4'h4);

        // blocked by exception, then accepted; jl taken
        opq(4'b0010, 1);
        opq(4'b0010, 0);
        jxx(4'h2);

        // cmovle with cc=0000 -> suppressed, with cc=0001 -> writes
        opq(4'b0000, 0);
        set_idle(); E_icode = 4'h2; E_ifun = 4'h1; E_dstE = 4'h3; alu_valE = 32'h1234; cycle();
        opq(4'b0001, 0);
        set_idle(); E_icode = 4'h2; E_ifun = 4'h1; E_dstE = 4'h3; alu_valE = 32'h5678; cycle();

        // bad stat blocks CC
        set_idle(); E_icode = 4'h6; E_stat = 3'h2; alu_cc = 4'b0110; cycle();

        // stall+bubble -> hold; bubble alone -> NOP
        opq(4'b0100, 0);
        set_idle(); E_icode = 4'h6; alu_cc = 4'b0010; alu_valE = 32'hDEAD; E_dstE = 4'h5;
        m_stall = 1; m_bubble = 1; cycle();
        set_idle(); E_icode = 4'h7; E_valA = 32'hBEEF; m_bubble = 1; cycle();

        // carry conditions
        opq(4'b1000, 0);
        jxx(4'h7);
        jxx(4'h8);
        opq(4'b0000, 0);
        jxx(4'h8);

        // reset mid-stream overrides everything
        set_idle(); rst = 1; m_stall = 1; mw_exc = 1; E_icode = 4'h6; alu_cc = 4'b0110; cycle();

        // randomized
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            set_idle();
            sel = $urandom_range(0, 4);
            E_icode  = (sel == 0) ? 4'h1 : (sel == 1) ? 4'h2 : (sel == 2) ? 4'h7 :
                       (sel == 3) ? 4'h6 : 4'($urandom);
            E_ifun   = 4'($urandom_range(0, 15));
            E_stat   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'h1;
            E_valA   = $urandom;
            E_dstE   = 4'($urandom);
            E_dstM   = 4'($urandom);
            alu_valE = $urandom;
            alu_cc   = 4'($urandom);
            mw_exc   = ($urandom_range(0, 5) == 0);
            m_stall  = ($urandom_range(0, 5) == 0);
            m_bubble = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 40) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
